// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and a constant clog2 helper used to size the bit counter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_behavioral.sv
// One-bit full subtractor cell: computes x - y - c_in as a difference bit
// and a borrow out.
module full_subtractor_behavioral (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic diff,
    output logic c_out
);

    assign diff  = x ^ y ^ c_in;
    assign c_out = (~x & y) | (~(x ^ y) & c_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell walked LSB-first over WIDTH clocks.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result_sh;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             diff;
    logic             c_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_behavioral u_cell (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (borrow),
        .diff  (diff),
        .c_out (c_out)
    );

    assign busy = (state == ST_RUN);

    // A start seen while done is high is dropped, so the earliest back-to-back
    // start is accepted on the edge after the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            result_sh  <= '0;
            borrow     <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
            result     <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        count  <= '0;
                        state  <= ST_RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    result_sh <= {diff, result_sh[WIDTH-1:1]};
                    borrow    <= c_out;
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    count     <= count + 1'b1;
                    if (count == LAST) state <= ST_DONE;
                end
                ST_DONE: begin
                    result     <= result_sh;
                    borrow_out <= borrow;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf        <= (a_msb != b_msb) && (result_sh[WIDTH-1] != a_msb);
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
